// File: rtl/mode_ctrl.sv
// mode_ctrl: top-level mode selector for the matrix calculator.
// A debounced press with a one-hot switch bank enters that mode; any other
// pattern starts a timed all-LED blink error window. An active mode returns
// to default on exit_req or, when MODE_CTRL_LONG_PRESS_EN is defined, on a
// long button hold that starts after the button has been released once.
//
// state     | meaning
// ST_IDLE   | default mode, LEDs mirror switches, waiting for a press
// ST_ERR    | invalid pattern, error window with LED blink
// ST_ACTIVE | mode mode_idx running, LED shows the selected mode
module mode_ctrl #(
  parameter int NUM_MODES         = 5,
  parameter int ERROR_CYCLES      = 50_000_000,
  parameter int BLINK_HALF_CYCLES = 6_250_000,
  parameter int LONG_PRESS_CYCLES = 100_000_000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 btn_press,
  input  logic                 btn_held,
  input  logic                 exit_req,
  input  logic [NUM_MODES-1:0] mode_sw,
  output logic [3:0]           mode_idx,
  output logic                 mode_enter,
  output logic                 mode_exit,
  output logic                 err_active,
  output logic [NUM_MODES-1:0] mode_led
);

  localparam int ERR_W = $clog2(ERROR_CYCLES + 1);
  localparam int BLK_W = $clog2(BLINK_HALF_CYCLES + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ERR, ST_ACTIVE} state_t;

  state_t           state_q, state_d;
  logic [3:0]       mode_idx_q, mode_idx_d;
  logic             mode_enter_q, mode_enter_d;
  logic             mode_exit_q, mode_exit_d;
  logic             err_active_q, err_active_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             blink_q, blink_d;
  logic             long_exit;
  logic [3:0]       sw_cnt;
  logic [3:0]       sw_idx;

`ifdef MODE_CTRL_LONG_PRESS_EN
  localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              armed_q, armed_d;
`else
  logic unused_long_press;
  assign unused_long_press = btn_held | (LONG_PRESS_CYCLES == 0);
`endif

  // Count set switches and remember the (1-based) index of the highest one.
  always_comb begin
    sw_cnt = 4'd0;
    sw_idx = 4'd0;
    for (int k = 0; k < NUM_MODES; k++) begin
      if (mode_sw[k]) begin
        sw_cnt = sw_cnt + 4'd1;
        sw_idx = 4'(k + 1);
      end
    end
  end

  // Next-state logic; timers are down-counters reloaded on ERR entry.
  always_comb begin
    state_d      = state_q;
    mode_idx_d   = mode_idx_q;
    mode_enter_d = 1'b0;
    mode_exit_d  = 1'b0;
    err_active_d = 1'b0;
    err_cnt_d    = '0;
    blink_cnt_d  = '0;
    blink_d      = 1'b0;
    long_exit    = 1'b0;
`ifdef MODE_CTRL_LONG_PRESS_EN
    hold_cnt_d   = '0;
    armed_d      = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (btn_press) begin
          if (sw_cnt == 4'd1) begin
            state_d      = ST_ACTIVE;
            mode_idx_d   = sw_idx;
            mode_enter_d = 1'b1;
          end else begin
            state_d      = ST_ERR;
            err_active_d = 1'b1;
            err_cnt_d    = ERR_W'(ERROR_CYCLES - 1);
            blink_cnt_d  = BLK_W'(BLINK_HALF_CYCLES - 1);
          end
        end
      end
      ST_ERR: begin
        if (err_cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          err_active_d = 1'b1;
          err_cnt_d    = err_cnt_q - ERR_W'(1);
          if (blink_cnt_q == '0) begin
            blink_d     = ~blink_q;
            blink_cnt_d = BLK_W'(BLINK_HALF_CYCLES - 1);
          end else begin
            blink_d     = blink_q;
            blink_cnt_d = blink_cnt_q - BLK_W'(1);
          end
        end
      end
      ST_ACTIVE: begin
`ifdef MODE_CTRL_LONG_PRESS_EN
        // Arming needs one released sample so the selecting press cannot exit.
        armed_d    = armed_q | ~btn_held;
        hold_cnt_d = (btn_held && armed_q) ? hold_cnt_q + HOLD_W'(1) : '0;
        long_exit  = btn_held && armed_q &&
                     (hold_cnt_q == HOLD_W'(LONG_PRESS_CYCLES - 1));
`endif
        if (exit_req || long_exit) begin
          state_d     = ST_IDLE;
          mode_idx_d  = 4'd0;
          mode_exit_d = 1'b1;
`ifdef MODE_CTRL_LONG_PRESS_EN
          hold_cnt_d  = '0;
          armed_d     = 1'b0;
`endif
        end
      end
      default: begin
        state_d    = ST_IDLE;
        mode_idx_d = 4'd0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      mode_idx_q   <= 4'd0;
      mode_enter_q <= 1'b0;
      mode_exit_q  <= 1'b0;
      err_active_q <= 1'b0;
      err_cnt_q    <= '0;
      blink_cnt_q  <= '0;
      blink_q      <= 1'b0;
`ifdef MODE_CTRL_LONG_PRESS_EN
      hold_cnt_q   <= '0;
      armed_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      mode_idx_q   <= mode_idx_d;
      mode_enter_q <= mode_enter_d;
      mode_exit_q  <= mode_exit_d;
      err_active_q <= err_active_d;
      err_cnt_q    <= err_cnt_d;
      blink_cnt_q  <= blink_cnt_d;
      blink_q      <= blink_d;
`ifdef MODE_CTRL_LONG_PRESS_EN
      hold_cnt_q   <= hold_cnt_d;
      armed_q      <= armed_d;
`endif
    end
  end

  // LED drive: switches in IDLE, blink in ERR, selected mode in ACTIVE.
  always_comb begin
    mode_led = mode_sw;
    case (state_q)
      ST_ERR:    mode_led = {NUM_MODES{blink_q}};
      ST_ACTIVE: mode_led = NUM_MODES'(1) << (mode_idx_q - 4'd1);
      default:   mode_led = mode_sw;
    endcase
  end

  assign mode_idx   = mode_idx_q;
  assign mode_enter = mode_enter_q;
  assign mode_exit  = mode_exit_q;
  assign err_active = err_active_q;

endmodule

// File: tb/tb_mode_ctrl.sv
// Bench for mode_ctrl: a behavioural model predicts each cycle's outputs,
// which are queued when stimulus is driven and compared after the edge.
module tb_mode_ctrl;

  localparam int NM = 5;
  localparam int EC = 20;
  localparam int BH = 4;
  localparam int LP = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          btn_press, btn_held, exit_req;
  logic [NM-1:0] mode_sw;
  logic [3:0]    mode_idx;
  logic          mode_enter, mode_exit, err_active;
  logic [NM-1:0] mode_led;

  int n_checks = 0;
  int n_fail   = 0;

  logic [11:0] exp_q[$];

  // model state: 0 idle, 1 err, 2 active
  int         m_state;
  logic [3:0] m_idx;
  int         m_t;
  int         m_hold;
  bit         m_armed;

  mode_ctrl #(
    .NUM_MODES(NM), .ERROR_CYCLES(EC),
    .BLINK_HALF_CYCLES(BH), .LONG_PRESS_CYCLES(LP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_press(btn_press), .btn_held(btn_held),
    .exit_req(exit_req), .mode_sw(mode_sw), .mode_idx(mode_idx),
    .mode_enter(mode_enter), .mode_exit(mode_exit), .err_active(err_active),
    .mode_led(mode_led)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_idx = 4'd0; m_t = 0; m_hold = 0; m_armed = 0;
  endtask

  task automatic model_step(input logic press, input logic held, input logic ex,
                            input logic [NM-1:0] sw, output logic [11:0] e);
    logic          ent, ext;
    logic [NM-1:0] led;
    bit            lp_hit;
    ent = 0; ext = 0; lp_hit = 0;
    case (m_state)
      0: if (press) begin
           if ($countones(sw) == 1) begin
             m_state = 2; m_armed = 0; m_hold = 0; ent = 1;
             for (int k = 0; k < NM; k++) if (sw[k]) m_idx = 4'(k + 1);
           end else begin
             m_state = 1; m_t = 0;
           end
         end
      1: begin
           m_t++;
           if (m_t == EC) begin m_state = 0; m_t = 0; end
         end
      default: begin
`ifdef MODE_CTRL_LONG_PRESS_EN
           if (held) begin
             if (m_armed) begin
               m_hold++;
               if (m_hold == LP) lp_hit = 1;
             end
           end else begin
             m_hold = 0; m_armed = 1;
           end
`endif
           if (ex || lp_hit) begin
             m_state = 0; m_idx = 4'd0; ext = 1; m_hold = 0; m_armed = 0;
           end
         end
    endcase
    if (m_state == 0)      led = sw;
    else if (m_state == 1) led = (((m_t / BH) % 2) == 1) ? '1 : '0;
    else                   led = NM'(1) << (m_idx - 4'd1);
    e = {m_idx, ent, ext, (m_state == 1), led};
  endtask

  // Drive one cycle of stimulus, queue the prediction, compare after the edge.
  task automatic step(input logic press, input logic held, input logic ex,
                      input logic [NM-1:0] sw);
    logic [11:0] e;
    btn_press = press; btn_held = held; exit_req = ex; mode_sw = sw;
    model_step(press, held, ex, sw, e);
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    chk("cycle", {mode_idx, mode_enter, mode_exit, err_active, mode_led}, exp_q.pop_front());
  endtask

  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    chk({tag, "_regs"}, {mode_idx, mode_enter, mode_exit, err_active}, 32'd0);
    chk({tag, "_led"}, mode_led, mode_sw);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; btn_press = 0; btn_held = 0; exit_req = 0; mode_sw = '0;
    model_reset();
    #1;
    chk("rst_regs", {mode_idx, mode_enter, mode_exit, err_active}, 32'd0);
    chk("rst_led", mode_led, mode_sw);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // valid select, LEDs then ignore switches
    repeat (2) step(0, 0, 0, 5'b00100);
    step(1, 0, 0, 5'b00100);
    chk("sel_idx", mode_idx, 3);
    chk("sel_enter", mode_enter, 1);
    chk("sel_led", mode_led, 5'b00100);
    step(0, 0, 0, 5'b11011);
    chk("sel_enter_fall", mode_enter, 0);
    chk("sel_led_hold", mode_led, 5'b00100);
    repeat (3) step(0, 0, 0, 5'b01001);
    step(0, 0, 1, 5'b01001);
    chk("exit_idx", mode_idx, 0);
    chk("exit_pulse", mode_exit, 1);

    // press in first IDLE cycle after exit, mode 1, exit, stray exit_req
    step(1, 0, 0, 5'b00001);
    chk("reentry_idx", mode_idx, 1);
    chk("reentry_exit_fall", mode_exit, 0);
    step(0, 0, 1, 5'b00000);
    chk("m1_exit", mode_exit, 1);
    step(0, 0, 1, 5'b00000);
    chk("idle_exit_ignored", mode_exit, 0);
    chk("idle_idx", mode_idx, 0);

    // invalid select with press at error cycle 10
    step(1, 0, 0, 5'b00110);
    chk("err_on", err_active, 1);
    for (int i = 1; i <= 22; i++) begin
      step((i == 10), 0, 0, 5'b00110);
      if (i == 19) chk("err_last", err_active, 1);
      if (i == 20) begin
        chk("err_off", err_active, 0);
        chk("err_idx", mode_idx, 0);
        chk("err_led_sw", mode_led, 5'b00110);
      end
    end
    step(1, 0, 0, 5'b00000);
    repeat (22) step(0, 0, 0, 5'b00000);
    chk("err0_done", err_active, 0);

    // long press behaviour
    step(1, 1, 0, 5'b00010);
    repeat (30) step(0, 1, 0, 5'b00010);
    chk("lp_select_hold", mode_idx, 2);
`ifdef MODE_CTRL_LONG_PRESS_EN
    step(0, 0, 0, 5'b00010);
    repeat (9) step(0, 1, 0, 5'b00010);
    chk("lp_9", mode_idx, 2);
    step(0, 0, 0, 5'b00010);
    repeat (10) step(0, 1, 0, 5'b00010);
    chk("lp_10_idx", mode_idx, 0);
    chk("lp_10_exit", mode_exit, 1);
    step(0, 0, 0, 5'b00010);
`else
    step(0, 0, 0, 5'b00010);
    repeat (50) step(0, 1, 0, 5'b00010);
    chk("nolp_50", mode_idx, 2);
    step(0, 0, 1, 5'b00010);
`endif

    // reset mid-ERR and mid-ACTIVE
    step(1, 0, 0, 5'b11000);
    repeat (5) step(0, 0, 0, 5'b11000);
    async_reset("rst_err");
    step(0, 0, 0, 5'b11000);
    step(1, 0, 0, 5'b01000);
    repeat (3) step(0, 0, 0, 5'b01000);
    async_reset("rst_act");
    step(0, 0, 0, 5'b01000);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic [NM-1:0] sw;
      case ($urandom_range(0, 3))
        0: sw = NM'(1) << $urandom_range(0, NM - 1);
        1: sw = NM'($urandom_range(0, 31));
        default: sw = mode_sw;
      endcase
      step(($urandom_range(0, 7) == 0), ($urandom_range(0, 5) != 0),
           ($urandom_range(0, 19) == 0), sw);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
